mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `memory` access unit between the instruction-fetch port (port 0) and the load/store port (port 1). It latches the winning request, sequences the memory unit's available/busy handshake including its mandatory release cycle, and returns read data and a fault flag to the winner with a one-cycle done pulse. It sits between the core's fetch/execute stages and `memory`.

---
 rtl/mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory unit between fetch (port 0) and load/store (port 1).
// Build option: MEM_ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_is_write,
    input  logic        p0_is_unsigned,
    input  logic [1:0]  p0_op,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_fault,

    input  logic        p1_req,
    input  logic        p1_is_write,
    input  logic        p1_is_unsigned,
    input  logic [1:0]  p1_op,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_fault,

    output logic        mem_available,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_out,
    input  logic        mem_busy,
    input  logic        mem_fault
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_WAIT    = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        sticky_q, sticky_d;
    logic        avail_q, avail_d;

    logic        is_write_q, is_write_d;
    logic        is_unsigned_q, is_unsigned_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        fault0_q, fault0_d;
    logic        fault1_q, fault1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        any_req;
    logic        winner;
    logic        fault_now;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic        ptr_q, ptr_d;
`endif

    assign any_req   = p0_req | p1_req;
    assign fault_now = sticky_q | mem_fault;

    // Winner selection: on contention the preferred port wins, else the sole requester.
    always_comb begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        winner = (p0_req && p1_req) ? ptr_q : p1_req;
`else
        winner = p1_req;
`endif
    end

    // Next-state and registered-output computation for the handshake FSM.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        sticky_d      = sticky_q;
        avail_d       = avail_q;
        is_write_d    = is_write_q;
        is_unsigned_d = is_unsigned_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        fault0_d      = fault0_q;
        fault1_d      = fault1_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d  = winner;
                    sticky_d = 1'b0;
                    avail_d  = 1'b1;
                    state_d  = S_ISSUE;
                    if (winner) begin
                        is_write_d    = p1_is_write;
                        is_unsigned_d = p1_is_unsigned;
                        op_d          = p1_op;
                        addr_d        = p1_addr;
                        wdata_d       = p1_wdata;
                    end else begin
                        is_write_d    = p0_is_write;
                        is_unsigned_d = p0_is_unsigned;
                        op_d          = p0_op;
                        addr_d        = p0_addr;
                        wdata_d       = p0_wdata;
                    end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    ptr_d = ~ptr_q;
`endif
                end
            end

            S_ISSUE: begin
                sticky_d = fault_now;
                if (mem_busy) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                sticky_d = fault_now;
                if (!mem_busy) begin
                    avail_d = 1'b0;
                    state_d = S_RELEASE;
                    if (owner_q) begin
                        done1_d  = 1'b1;
                        fault1_d = fault_now;
                        rdata1_d = mem_out;
                    end else begin
                        done0_d  = 1'b1;
                        fault0_d = fault_now;
                        rdata0_d = mem_out;
                    end
                end
            end

            S_RELEASE: begin
                avail_d = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                avail_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, owner, sticky fault and memory available strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            sticky_q <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            sticky_q <= sticky_d;
            avail_q  <= avail_d;
        end
    end

    // Latched request fields presented to the memory unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_write_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            op_q          <= 2'b00;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
        end else begin
            is_write_q    <= is_write_d;
            is_unsigned_q <= is_unsigned_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    // Per-port response registers: done pulse, fault status and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            fault0_q <= 1'b0;
            fault1_q <= 1'b0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            fault0_q <= fault0_d;
            fault1_q <= fault1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Round-robin pointer naming the port preferred at the next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign mem_available   = avail_q;
    assign mem_is_write    = is_write_q;
    assign mem_is_unsigned = is_unsigned_q;
    assign mem_op          = op_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;

    assign p0_done  = done0_q;
    assign p0_fault = fault0_q;
    assign p0_rdata = rdata0_q;
    assign p1_done  = done1_q;
    assign p1_fault = fault1_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small memory handshake model.
// Build option: MEM_ARBITER_ROUND_ROBIN_EN switches expected grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        p0_req, p0_is_write, p0_is_unsigned;
    logic [1:0]  p0_op;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p0_done, p0_fault;

    logic        p1_req, p1_is_write, p1_is_unsigned;
    logic [1:0]  p1_op;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        p1_done, p1_fault;

    logic        mem_available, mem_is_write, mem_is_unsigned;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata, mem_out;
    logic        mem_busy, mem_fault;

    int          n_chk  = 0;
    int          n_pass = 0;

    int          extra_wait;
    logic        fault_arm;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .p0_req          (p0_req),
        .p0_is_write     (p0_is_write),
        .p0_is_unsigned  (p0_is_unsigned),
        .p0_op           (p0_op),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_rdata        (p0_rdata),
        .p0_done         (p0_done),
        .p0_fault        (p0_fault),
        .p1_req          (p1_req),
        .p1_is_write     (p1_is_write),
        .p1_is_unsigned  (p1_is_unsigned),
        .p1_op           (p1_op),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_rdata        (p1_rdata),
        .p1_done         (p1_done),
        .p1_fault        (p1_fault),
        .mem_available   (mem_available),
        .mem_is_write    (mem_is_write),
        .mem_is_unsigned (mem_is_unsigned),
        .mem_op          (mem_op),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_out         (mem_out),
        .mem_busy        (mem_busy),
        .mem_fault       (mem_fault)
    );

    // Memory model: busy one cycle after available, held extra_wait more cycles,
    // fault pulsed on the first busy cycle when armed, then waits for release.
    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t mst;
    int   mcnt;

    always @(posedge clk) begin
        if (reset) begin
            mst       <= M_IDLE;
            mem_busy  <= 1'b0;
            mem_fault <= 1'b0;
            mem_out   <= 32'h0;
            mcnt      <= 0;
        end else begin
            case (mst)
                M_IDLE: if (mem_available) begin
                    mem_busy  <= 1'b1;
                    mem_fault <= fault_arm;
                    mcnt      <= extra_wait;
                    mst       <= M_BUSY;
                end
                M_BUSY: begin
                    mem_fault <= 1'b0;
                    if (mcnt == 0) begin
                        mem_busy <= 1'b0;
                        mem_out  <= rd_val;
                        mst      <= M_DONE;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
                default: if (!mem_available) mst <= M_IDLE;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for any done pulse; cyc counts clock edges from the request cycle.
    task automatic wait_done(output int cyc, output logic [1:0] who);
        cyc = 0;
        who = 2'b00;
        while (who == 2'b00 && cyc < 40) begin
            step();
            cyc++;
            who = {p1_done, p0_done};
        end
        if (who == 2'b00) check("timeout", 32'd0, 32'd1);
    endtask

    int          c, c2;
    logic [1:0]  w;
    logic        bad;
    logic [1:0]  exp_first, exp_second;

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_is_write = 0; p0_is_unsigned = 0; p0_op = 0;
        p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_is_write = 0; p1_is_unsigned = 0; p1_op = 0;
        p1_addr = 0; p1_wdata = 0;
        extra_wait = 0; fault_arm = 0; rd_val = 0;
        @(negedge clk);
        do_reset();

        check("rst_avail", 32'(mem_available), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_done", 32'({p1_done, p0_done}), 32'd0);
        check("rst_rdata0", p0_rdata, 32'd0);

        // Port 0 word read, zero-wait memory.
        rd_val = 32'hDEADBEEF;
        p0_req = 1; p0_op = 2'b10; p0_addr = 32'h100;
        wait_done(c, w);
        check("t1_cyc", c, 4);
        check("t1_who", 32'(w), 32'd1);
        check("t1_rdata", p0_rdata, 32'hDEADBEEF);
        check("t1_fault", 32'(p0_fault), 32'd0);
        check("t1_avail", 32'(mem_available), 32'd0);
        check("t1_maddr", mem_addr, 32'h100);
        check("t1_mop", 32'(mem_op), 32'd2);
        p0_req = 0;
        step(); step();

        // Port 1 half write with a fault during ISSUE.
        fault_arm = 1; rd_val = 32'h0;
        p1_req = 1; p1_is_write = 1; p1_op = 2'b01;
        p1_addr = 32'h203; p1_wdata = 32'hCAFE1234;
        wait_done(c, w);
        check("t2_cyc", c, 4);
        check("t2_who", 32'(w), 32'd2);
        check("t2_fault", 32'(p1_fault), 32'd1);
        check("t2_mwr", 32'(mem_is_write), 32'd1);
        check("t2_mwdata", mem_wdata, 32'hCAFE1234);
        check("t2_p0hold", p0_rdata, 32'hDEADBEEF);
        p1_req = 0; fault_arm = 0; p1_is_write = 0;
        step(); step();

        // Simultaneous requests held through two transactions.
        do_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_first = 2'b01; exp_second = 2'b10;
`else
        exp_first = 2'b10; exp_second = 2'b01;
`endif
        rd_val = 32'hAAAA0001;
        p0_req = 1; p0_addr = 32'h10; p0_op = 2'b10;
        p1_req = 1; p1_addr = 32'h20; p1_op = 2'b10;
        wait_done(c, w);
        check("t3_cyc1", c, 4);
        check("t3_who1", 32'(w), 32'(exp_first));
        if (w[0]) p0_req = 0;
        else      p1_req = 0;
        rd_val = 32'hBBBB0002;
        wait_done(c2, w);
        check("t3_cyc2", c + c2, 9);
        check("t3_who2", 32'(w), 32'(exp_second));
        check("t3_rd", w[0] ? p0_rdata : p1_rdata, 32'hBBBB0002);
        p0_req = 0; p1_req = 0;
        step(); step();

        // Both ports requesting continuously for six transactions.
        do_reset();
        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 6; i++) begin
            wait_done(c, w);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            check($sformatf("t4_who%0d", i), 32'(w),
                  (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            check($sformatf("t4_who%0d", i), 32'(w), 32'd2);
`endif
            check($sformatf("t4_cyc%0d", i), c, (i == 0) ? 4 : 5);
        end
        p0_req = 0; p1_req = 0;
        step(); step();

        // Slow memory: three extra busy cycles, requester fields change after grant.
        extra_wait = 3; rd_val = 32'h12345678;
        p0_req = 1; p0_addr = 32'h400; p0_op = 2'b10;
        c = 0; bad = 0; w = 0;
        while (w == 2'b00 && c < 40) begin
            step();
            c++;
            if (c == 1) begin
                p0_addr = 32'h999;
                p0_op   = 2'b00;
            end
            if (mem_addr != 32'h400 || mem_op != 2'b10) bad = 1;
            w = {p1_done, p0_done};
        end
        check("t5_cyc", c, 7);
        check("t5_stable", 32'(bad), 32'd0);
        check("t5_rdata", p0_rdata, 32'h12345678);
        p0_req = 0;
        step(); step();

        // Reset asserted while waiting on memory.
        extra_wait = 5; rd_val = 32'h55555555;
        p0_req = 1; p0_addr = 32'h500; p0_op = 2'b10;
        repeat (4) step();
        check("t6_inwait", 32'(mem_available), 32'd1);
        reset = 1; p0_req = 0;
        step();
        check("t6_avail", 32'(mem_available), 32'd0);
        check("t6_done", 32'({p1_done, p0_done}), 32'd0);
        check("t6_rdata0", p0_rdata, 32'd0);
        check("t6_fields", 32'({mem_is_write, mem_is_unsigned, mem_op}), 32'd0);
        check("t6_maddr", mem_addr, 32'd0);
        reset = 0;
        bad = 0;
        repeat (8) begin
            step();
            if (p0_done || p1_done) bad = 1;
        end
        check("t6_nodone", 32'(bad), 32'd0);
        extra_wait = 0; rd_val = 32'h0BADF00D;
        p0_req = 1; p0_addr = 32'h600;
        wait_done(c, w);
        check("t6_after_cyc", c, 4);
        check("t6_after_rd", p0_rdata, 32'h0BADF00D);
        p0_req = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
